// File: rtl/usb_utmi_pkg.sv
// Shared UTMI encodings, line-controller state types and default timing constants.
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    LsSe0 = 2'b00,
    LsJ   = 2'b01,
    LsK   = 2'b10,
    LsSe1 = 2'b11
  } line_state_e;

  typedef enum logic [1:0] {
    OpNormal   = 2'b00,
    OpNonDrive = 2'b01,
    OpNoStuff  = 2'b10,
    OpRsvd     = 2'b11
  } op_mode_e;

  typedef enum logic [2:0] {
    StActive,
    StReset,
    StSuspend,
    StResume,
    StRwuK
  } line_ctrl_st_e;

  // Which line condition the shared idle counter is currently timing.
  typedef enum logic [1:0] {
    CondNone,
    CondSe0,
    CondIdle,
    CondRun
  } line_cond_e;

  // Cycle counts at 48 MHz.
  localparam int unsigned RstCycDef     = 120;     // 2.5 us
  localparam int unsigned SuspCycDef    = 144000;  // 3 ms
  localparam int unsigned RwuWaitCycDef = 240000;  // 5 ms
  localparam int unsigned RwuKCycDef    = 96000;   // 2 ms

  function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/usb_line_ctrl_if.sv
// Line-controller signal bundle between the UTM/link side and the controller.
interface usb_line_ctrl_if;

  usb_utmi_pkg::line_state_e line_state;
  logic                      rx_active;
  logic                      tx_valid;
  logic                      rwu_req;
  logic                      suspend_m;
  usb_utmi_pkg::op_mode_e    op_mode;
  logic                      drive_k;
  logic                      bus_reset;
  logic                      suspended;
  logic                      resume_evt;

  modport master (
    output line_state, rx_active, tx_valid, rwu_req,
    input  suspend_m, op_mode, drive_k, bus_reset, suspended, resume_evt
  );

  modport slave (
    input  line_state, rx_active, tx_valid, rwu_req,
    output suspend_m, op_mode, drive_k, bus_reset, suspended, resume_evt
  );

endinterface

// File: rtl/usb_line_ctrl.sv
// USB device line-state controller: bus reset / suspend detection, resume and remote wakeup.
// Drives suspend_m/op_mode of the neighbouring UTM; all outputs are registered.
module usb_line_ctrl
  import usb_utmi_pkg::*;
#(
  parameter int unsigned RST_CYC      = RstCycDef,
  parameter int unsigned SUSP_CYC     = SuspCycDef,
  parameter int unsigned RWU_WAIT_CYC = RwuWaitCycDef,
  parameter int unsigned RWU_K_CYC    = RwuKCycDef
) (
  input logic            clk,
  input logic            rst,
  usb_line_ctrl_if.slave utmi
);

  localparam int unsigned MaxCyc = max_cyc(RST_CYC, SUSP_CYC, RWU_WAIT_CYC, RWU_K_CYC);
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] CntMax     = '1;
  localparam logic [CntW-1:0] RstCnt     = CntW'(RST_CYC);
  localparam logic [CntW-1:0] SuspCnt    = CntW'(SUSP_CYC);
  localparam logic [CntW-1:0] RwuWaitCnt = CntW'(RWU_WAIT_CYC);
  localparam logic [CntW-1:0] RwuKCnt    = CntW'(RWU_K_CYC);

  line_ctrl_st_e   state_q, state_d;
  line_cond_e      cond, cond_q, cond_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            rwu_pend_q, rwu_pend_d;
  logic            suspend_m_q, suspend_m_d;
  op_mode_e        op_mode_q, op_mode_d;
  logic            drive_k_q, drive_k_d;
  logic            bus_reset_q, bus_reset_d;
  logic            suspended_q, suspended_d;
  logic            resume_evt_q, resume_evt_d;

  logic se0, line_j;
  assign se0    = (utmi.line_state == LsSe0);
  assign line_j = (utmi.line_state == LsJ);

  // Qualifying condition for the current state; SE1 and K never qualify.
  always_comb begin
    cond = CondNone;
    unique case (state_q)
      StActive: begin
        if (se0) cond = CondSe0;
        else if (line_j && !utmi.rx_active && !utmi.tx_valid) cond = CondIdle;
      end
      StSuspend: begin
        if (se0) cond = CondSe0;
        else if (line_j) cond = CondIdle;
      end
      StResume: begin
        if (se0) cond = CondSe0;
      end
      StRwuK:  cond = CondRun;
      default: cond = CondNone;
    endcase
  end

  // Run length including the current sample; restarts whenever the condition changes.
  always_comb begin
    if (cond == CondNone)      cnt_inc = '0;
    else if (cond != cond_q)   cnt_inc = CntW'(1);
    else if (cnt_q == CntMax)  cnt_inc = cnt_q;
    else                       cnt_inc = cnt_q + CntW'(1);
  end

  always_comb begin
    state_d      = state_q;
    rwu_pend_d   = rwu_pend_q;
    resume_evt_d = 1'b0;
    unique case (state_q)
      StActive: begin
        if (cond == CondSe0 && cnt_inc >= RstCnt)        state_d = StReset;
        else if (cond == CondIdle && cnt_inc >= SuspCnt) state_d = StSuspend;
      end
      StReset: begin
        if (!se0) state_d = StActive;
      end
      StSuspend: begin
        if (cond == CondSe0 && cnt_inc >= RstCnt) begin
          state_d = StReset;
        end else if (utmi.line_state == LsK) begin
          state_d = StResume;
        end else if (cond == CondIdle && cnt_inc >= RwuWaitCnt &&
                     (rwu_pend_q || utmi.rwu_req)) begin
          state_d = StRwuK;
        end else if (utmi.rwu_req) begin
          rwu_pend_d = 1'b1;
        end
        if (state_d != StSuspend) begin
          resume_evt_d = 1'b1;
          rwu_pend_d   = 1'b0;
        end
      end
      StRwuK: begin
        if (cnt_inc >= RwuKCnt) state_d = StResume;
      end
      StResume: begin
        if (cond == CondSe0 && cnt_inc >= RstCnt) state_d = StReset;
        else if (cond_q == CondSe0 && line_j)     state_d = StActive;  // host EOP
      end
      default: state_d = StActive;
    endcase

    cond_d = (state_d != state_q) ? CondNone : cond;
    cnt_d  = (state_d != state_q) ? '0 : cnt_inc;

    suspend_m_d = (state_d != StSuspend);
    suspended_d = (state_d == StSuspend);
    drive_k_d   = (state_d == StRwuK);
    op_mode_d   = (state_d == StRwuK) ? OpNoStuff : OpNormal;
    bus_reset_d = (state_d == StReset);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StActive;
      cond_q       <= CondNone;
      cnt_q        <= '0;
      rwu_pend_q   <= 1'b0;
      suspend_m_q  <= 1'b1;
      op_mode_q    <= OpNormal;
      drive_k_q    <= 1'b0;
      bus_reset_q  <= 1'b0;
      suspended_q  <= 1'b0;
      resume_evt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cond_q       <= cond_d;
      cnt_q        <= cnt_d;
      rwu_pend_q   <= rwu_pend_d;
      suspend_m_q  <= suspend_m_d;
      op_mode_q    <= op_mode_d;
      drive_k_q    <= drive_k_d;
      bus_reset_q  <= bus_reset_d;
      suspended_q  <= suspended_d;
      resume_evt_q <= resume_evt_d;
    end
  end

  assign utmi.suspend_m  = suspend_m_q;
  assign utmi.op_mode    = op_mode_q;
  assign utmi.drive_k    = drive_k_q;
  assign utmi.bus_reset  = bus_reset_q;
  assign utmi.suspended  = suspended_q;
  assign utmi.resume_evt = resume_evt_q;

endmodule

// File: tb/tb_usb_line_ctrl.sv
// Self-checking bench for usb_line_ctrl: directed scenarios plus randomized line traffic
// compared every cycle against a history-based reference model.
module tb_usb_line_ctrl;
  import usb_utmi_pkg::*;

  localparam int unsigned RstCyc  = 4;
  localparam int unsigned SuspCyc = 20;
  localparam int unsigned WaitCyc = 30;
  localparam int unsigned KCyc    = 10;

  localparam int ModeActive = 0;
  localparam int ModeReset  = 1;
  localparam int ModeSusp   = 2;
  localparam int ModeResume = 3;
  localparam int ModeRwuK   = 4;

  // Packed outputs: {suspend_m, op_mode[1:0], drive_k, bus_reset, suspended, resume_evt}
  localparam logic [6:0] OutIdle    = 7'b1_00_0_0_0_0;
  localparam logic [6:0] OutSusp    = 7'b0_00_0_0_1_0;
  localparam logic [6:0] OutResEvt  = 7'b1_00_0_0_0_1;
  localparam logic [6:0] OutBusRst  = 7'b1_00_0_1_0_0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  usb_line_ctrl_if u ();

  usb_line_ctrl #(
    .RST_CYC     (RstCyc),
    .SUSP_CYC    (SuspCyc),
    .RWU_WAIT_CYC(WaitCyc),
    .RWU_K_CYC   (KCyc)
  ) dut (
    .clk (clk),
    .rst (rst),
    .utmi(u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remembers the samples seen since the current mode was entered.
  typedef struct packed {
    logic [1:0] ls;
    logic       rx;
    logic       tx;
  } smp_t;

  smp_t hist[$];
  int   m_mode;
  int   m_n;
  bit   m_pend;
  bit   m_evt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int trail_ls(input logic [1:0] ls);
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].ls != ls) break;
      n++;
    end
    return n;
  endfunction

  function automatic int trail_idle();
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].ls != 2'b01 || hist[i].rx || hist[i].tx) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [6:0] model_pack();
    logic [6:0] p;
    p[6]   = (m_mode != ModeSusp);
    p[5:4] = (m_mode == ModeRwuK) ? 2'b10 : 2'b00;
    p[3]   = (m_mode == ModeRwuK);
    p[2]   = (m_mode == ModeReset);
    p[1]   = (m_mode == ModeSusp);
    p[0]   = m_evt;
    return p;
  endfunction

  function automatic logic [6:0] dut_pack();
    return {u.suspend_m, u.op_mode, u.drive_k, u.bus_reset, u.suspended, u.resume_evt};
  endfunction

  task automatic model_step(input logic [1:0] ls, input logic rx, input logic tx,
                            input logic rwu);
    int   nxt;
    smp_t s;
    m_evt = 1'b0;
    if (rst) begin
      m_mode = ModeActive;
      hist.delete();
      m_pend = 1'b0;
      m_n    = 0;
      return;
    end
    s.ls = ls;
    s.rx = rx;
    s.tx = tx;
    hist.push_back(s);
    if (hist.size() > 64) void'(hist.pop_front());
    m_n++;
    nxt = m_mode;
    case (m_mode)
      ModeActive: begin
        if (trail_ls(2'b00) >= RstCyc)   nxt = ModeReset;
        else if (trail_idle() >= SuspCyc) nxt = ModeSusp;
      end
      ModeReset: if (ls != 2'b00) nxt = ModeActive;
      ModeSusp: begin
        if (trail_ls(2'b00) >= RstCyc) nxt = ModeReset;
        else if (ls == 2'b10) nxt = ModeResume;
        else if (trail_ls(2'b01) >= WaitCyc && (m_pend || rwu)) nxt = ModeRwuK;
        else if (rwu) m_pend = 1'b1;
      end
      ModeRwuK: if (m_n >= KCyc) nxt = ModeResume;
      ModeResume: begin
        if (trail_ls(2'b00) >= RstCyc) nxt = ModeReset;
        else if (hist.size() >= 2 && hist[hist.size()-2].ls == 2'b00 && ls == 2'b01)
          nxt = ModeActive;
      end
      default: nxt = ModeActive;
    endcase
    if (nxt != m_mode) begin
      m_evt  = (m_mode == ModeSusp);
      hist.delete();
      m_pend = 1'b0;
      m_n    = 0;
      m_mode = nxt;
    end
  endtask

  // One clock: drive inputs, let DUT and model see the same edge, compare after it.
  task automatic step(input logic [1:0] ls, input logic rx, input logic tx, input logic rwu);
    u.line_state = line_state_e'(ls);
    u.rx_active  = rx;
    u.tx_valid   = tx;
    u.rwu_req    = rwu;
    @(posedge clk);
    model_step(ls, rx, tx, rwu);
    #1;
    check_eq("cycle", 32'(dut_pack()), 32'(model_pack()));
  endtask

  task automatic steps(input int n, input logic [1:0] ls);
    for (int i = 0; i < n; i++) step(ls, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int rise_at;
    int k_len;
    int k_op;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    m_mode   = ModeActive;
    m_n      = 0;
    m_pend   = 1'b0;
    m_evt    = 1'b0;

    do_reset();
    check_eq("reset_state", 32'(dut_pack()), 32'(OutIdle));

    // Bus reset: short SE0 ignored, RstCyc SE0 asserts until first J.
    steps(3, 2'b00);
    check_eq("se0_short", 32'(u.bus_reset), 32'd0);
    steps(1, 2'b01);
    steps(4, 2'b00);
    check_eq("se0_reset", 32'(dut_pack()), 32'(OutBusRst));
    steps(3, 2'b00);
    check_eq("reset_hold", 32'(u.bus_reset), 32'd1);
    steps(1, 2'b01);
    check_eq("reset_exit", 32'(dut_pack()), 32'(OutIdle));

    // Suspend entry, host resume, EOP back to active.
    steps(19, 2'b01);
    check_eq("susp_early", 32'(u.suspended), 32'd0);
    steps(1, 2'b01);
    check_eq("susp_entry", 32'(dut_pack()), 32'(OutSusp));
    steps(1, 2'b10);
    check_eq("resume_evt", 32'(dut_pack()), 32'(OutResEvt));
    steps(1, 2'b10);
    check_eq("resume_pulse_end", 32'(dut_pack()), 32'(OutIdle));
    steps(1, 2'b00);
    steps(1, 2'b01);
    steps(19, 2'b01);
    check_eq("back_active", 32'(dut_pack()), 32'(OutIdle));
    steps(1, 2'b01);
    check_eq("resuspend", 32'(dut_pack()), 32'(OutSusp));

    // Idle interrupted by rx_active.
    do_reset();
    steps(10, 2'b01);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    steps(8, 2'b01);
    check_eq("idle_rx_break", 32'(dut_pack()), 32'(OutIdle));

    // Early remote-wakeup request is held until the suspend dwell completes.
    do_reset();
    steps(SuspCyc, 2'b01);
    rise_at = -1;
    k_len   = 0;
    k_op    = 0;
    for (int d = 1; d <= 45; d++) begin
      step(2'b01, 1'b0, 1'b0, (d == 5));
      if (u.drive_k && rise_at < 0) rise_at = d;
      if (u.drive_k) k_len++;
      if (u.drive_k && u.op_mode == OpNoStuff) k_op++;
    end
    check_eq("rwu_rise", 32'(rise_at), 32'(WaitCyc));
    check_eq("rwu_len", 32'(k_len), 32'(KCyc));
    check_eq("rwu_opmode", 32'(k_op), 32'(KCyc));
    check_eq("rwu_after", 32'(dut_pack()), 32'(OutIdle));
    steps(1, 2'b00);
    steps(1, 2'b01);

    // Reset in the middle of the wakeup K.
    do_reset();
    steps(SuspCyc, 2'b01);
    step(2'b01, 1'b0, 1'b0, 1'b1);
    steps(WaitCyc + 2, 2'b01);
    check_eq("rwuk_active", 32'(u.drive_k), 32'd1);
    rst = 1'b1;
    step(2'b01, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check_eq("rst_mid_rwuk", 32'(dut_pack()), 32'(OutIdle));

    // rwu_req while active is dropped.
    step(2'b01, 1'b0, 1'b0, 1'b1);
    steps(SuspCyc + WaitCyc, 2'b01);
    check_eq("rwu_ignored", 32'(dut_pack()), 32'(OutSusp));

    // SE1 is never idle and never a transition.
    do_reset();
    steps(50, 2'b11);
    check_eq("se1_hold", 32'(dut_pack()), 32'(OutIdle));

    // Randomized line traffic in runs so that long conditions actually occur.
    for (int r = 0; r < 400; r++) begin
      int          cls;
      int          len;
      logic [1:0]  ls;
      bit          noisy;
      cls   = $urandom_range(0, 9);
      len   = $urandom_range(1, 36);
      noisy = ($urandom_range(0, 3) == 0);
      if (cls < 2)      ls = 2'b00;
      else if (cls < 6) ls = 2'b01;
      else if (cls < 8) ls = 2'b10;
      else              ls = 2'b11;
      if ($urandom_range(0, 59) == 0) rst = 1'b1;
      for (int i = 0; i < len; i++) begin
        step(ls, noisy && ($urandom_range(0, 5) == 0), noisy && ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 29) == 0));
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
